// File: rtl/core_mem_pkg.sv
// Shared types for the core memory-port arbiter: FSM state, transaction owner
// and the request slot layout.
package core_mem_pkg;

  localparam int CORE_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_owner_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0]   addr;
    logic                   wen;
    logic [CORE_XLEN-1:0]   wdata;
    logic [CORE_XLEN/8-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// Fetch/data arbiter in front of a single memory bus port: one outstanding
// transaction, data-first priority with a fetch starvation guard and fetch flush.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int MAX_I_WAIT = 4,
  parameter int XLEN       = CORE_XLEN  // slot layout is fixed by the package
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic              i_flush,
  output logic              i_rsp_valid,
  output logic [XLEN-1:0]   i_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_wen,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [XLEN/8-1:0] d_req_be,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic              bus_req_wen,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_be,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rsp_rdata
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_I_WAIT);

  arb_state_t state;
  arb_owner_t owner;
  logic       drop;
  logic [7:0] wait_cnt;
  mem_req_t   slot;
  logic       d_grant, i_grant;
  logic       i_starved;

  assign i_starved = (wait_cnt >= WAIT_MAX);

  // Grants are masked by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    d_grant = 1'b0;
    i_grant = 1'b0;
    if (rst_n && state == IDLE) begin
      if (d_req_valid && (!i_starved || !i_req_valid)) d_grant = 1'b1;
      else if (i_req_valid && !i_flush)                  i_grant = 1'b1;
    end
  end

  assign d_req_ready = d_grant;
  assign i_req_ready = i_grant;

  assign bus_req_valid = (state == REQ);
  assign bus_req_addr  = slot.addr;
  assign bus_req_wen   = slot.wen;
  assign bus_req_wdata = slot.wdata;
  assign bus_req_be    = slot.be;

  // A flush coinciding with the response kills it even before drop is set.
  assign i_rsp_valid = (state == RSP) && bus_rsp_valid && (owner == FETCH) && !drop && !i_flush;
  assign d_rsp_valid = (state == RSP) && bus_rsp_valid && (owner == DATA) && !drop;
  assign i_rsp_rdata = bus_rsp_rdata;
  assign d_rsp_rdata = bus_rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= NONE;
      drop     <= 1'b0;
      wait_cnt <= '0;
      slot     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_grant) begin
            slot  <= '{addr: d_req_addr, wen: d_req_wen, wdata: d_req_wdata, be: d_req_be};
            owner <= DATA;
            state <= REQ;
            if (i_req_valid && !i_starved) wait_cnt <= wait_cnt + 8'd1;
          end else if (i_grant) begin
            slot     <= '{addr: i_req_addr, wen: 1'b0, wdata: '0, be: '1};
            owner    <= FETCH;
            state    <= REQ;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (i_flush && owner == FETCH) drop <= 1'b1;
          if (bus_req_ready) state <= RSP;
        end
        RSP: begin
          if (bus_rsp_valid) begin
            state <= IDLE;
            owner <= NONE;
            drop  <= 1'b0;
          end else if (i_flush && owner == FETCH) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are only legal while a transaction is waiting for one.
  a_rsp_in_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    bus_rsp_valid |-> state == RSP);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: fetch, data, starvation, backpressure,
// flush and mid-transaction reset.
module tb_core_mem_arbiter;
  import core_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_flush, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_wen, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [3:0]  d_req_be, bus_req_be;
  logic        bus_req_valid, bus_req_ready, bus_req_wen, bus_rsp_valid;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  core_mem_arbiter #(.MAX_I_WAIT(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge, outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0; i_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_wen = 1'b0; d_req_wdata = '0; d_req_be = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;

    // reset state
    #3;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_owner", 32'(dut.owner), 32'(NONE));
    chk1("rst_drop", dut.drop, 1'b0);
    chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    chk1("rst_bus_valid", bus_req_valid, 1'b0);
    chk("rst_bus_addr", bus_req_addr, 32'h0);
    chk1("rst_i_ready", i_req_ready, 1'b0);
    chk1("rst_d_ready", d_req_ready, 1'b0);
    chk1("rst_i_rsp", i_rsp_valid, 1'b0);
    chk1("rst_d_rsp", d_rsp_valid, 1'b0);
    #9 rst_n = 1'b1;

    // lone fetch
    tick(); i_req_valid = 1'b1; i_req_addr = 32'h100; bus_req_ready = 1'b1; #1;
    chk1("f1_i_ready", i_req_ready, 1'b1);
    chk1("f1_d_ready", d_req_ready, 1'b0);
    tick(); i_req_valid = 1'b0; #1;
    chk1("f1_bus_valid", bus_req_valid, 1'b1);
    chk("f1_bus_addr", bus_req_addr, 32'h100);
    chk1("f1_bus_wen", bus_req_wen, 1'b0);
    chk("f1_bus_be", 32'(bus_req_be), 32'hF);
    chk1("f1_i_ready_req", i_req_ready, 1'b0);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h13; #1;
    chk1("f1_i_rsp", i_rsp_valid, 1'b1);
    chk("f1_i_rdata", i_rsp_rdata, 32'h13);
    chk1("f1_d_rsp", d_rsp_valid, 1'b0);
    tick(); bus_rsp_valid = 1'b0; #1;
    chk("f1_idle", 32'(dut.state), 32'(IDLE));
    chk1("f1_bus_idle", bus_req_valid, 1'b0);

    // simultaneous fetch and store: data first, then fetch
    tick();
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h8000_0004; d_req_wen = 1'b1;
    d_req_wdata = 32'hDEAD_BEEF; d_req_be = 4'b1111; #1;
    chk1("sim_d_ready", d_req_ready, 1'b1);
    chk1("sim_i_ready", i_req_ready, 1'b0);
    tick(); d_req_valid = 1'b0; d_req_wen = 1'b0; #1;
    chk1("sim_bus_wen", bus_req_wen, 1'b1);
    chk("sim_bus_addr", bus_req_addr, 32'h8000_0004);
    chk("sim_bus_wdata", bus_req_wdata, 32'hDEAD_BEEF);
    chk("sim_bus_be", 32'(bus_req_be), 32'hF);
    chk("sim_wait_1", 32'(dut.wait_cnt), 32'd1);
    chk1("sim_i_ready_req", i_req_ready, 1'b0);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0; #1;
    chk1("sim_d_ack", d_rsp_valid, 1'b1);
    chk1("sim_no_i_rsp", i_rsp_valid, 1'b0);
    tick(); bus_rsp_valid = 1'b0; #1;
    chk1("sim_i_grant", i_req_ready, 1'b1);
    tick(); i_req_valid = 1'b0; #1;
    chk("sim_wait_0", 32'(dut.wait_cnt), 32'd0);
    chk("sim_f_addr", bus_req_addr, 32'h200);
    chk1("sim_f_wen", bus_req_wen, 1'b0);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0000_0093; #1;
    chk1("sim_i_rsp", i_rsp_valid, 1'b1);
    chk("sim_i_rdata", i_rsp_rdata, 32'h93);
    tick(); bus_rsp_valid = 1'b0; #1;

    // starvation: four data wins, then fetch while data is still valid
    d_req_addr = 32'h40; d_req_wen = 1'b0; d_req_be = 4'b1111; i_req_addr = 32'h280;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      bus_rsp_valid = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1; #1;
      chk($sformatf("stv_cnt_%0d", k), 32'(dut.wait_cnt), 32'(k));
      chk1($sformatf("stv_d_ready_%0d", k), d_req_ready, (k < 4));
      chk1($sformatf("stv_i_ready_%0d", k), i_req_ready, (k == 4));
      tick(); #1;
      tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'(k); #1;
      chk1($sformatf("stv_d_rsp_%0d", k), d_rsp_valid, (k < 4));
      chk1($sformatf("stv_i_rsp_%0d", k), i_rsp_valid, (k == 4));
    end
    tick(); bus_rsp_valid = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0; #1;
    chk("stv_cnt_clr", 32'(dut.wait_cnt), 32'd0);
    chk("stv_idle", 32'(dut.state), 32'(IDLE));

    // bus backpressure: request must hold steady, no grants
    tick(); d_req_valid = 1'b1; d_req_addr = 32'h44; d_req_be = 4'b0011; bus_req_ready = 1'b0; #1;
    chk1("bp_d_ready", d_req_ready, 1'b1);
    for (int j = 0; j < 5; j++) begin
      tick(); i_req_valid = 1'b1; d_req_addr = 32'h999; d_req_be = 4'b1100; #1;
      chk1($sformatf("bp_valid_%0d", j), bus_req_valid, 1'b1);
      chk($sformatf("bp_addr_%0d", j), bus_req_addr, 32'h44);
      chk($sformatf("bp_be_%0d", j), 32'(bus_req_be), 32'h3);
      chk1($sformatf("bp_d_ready_%0d", j), d_req_ready, 1'b0);
      chk1($sformatf("bp_i_ready_%0d", j), i_req_ready, 1'b0);
    end
    tick(); bus_req_ready = 1'b1; #1;
    chk1("bp_hs_valid", bus_req_valid, 1'b1);
    chk("bp_hs_addr", bus_req_addr, 32'h44);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h55; d_req_valid = 1'b0; i_req_valid = 1'b0; #1;
    chk1("bp_d_rsp", d_rsp_valid, 1'b1);
    chk("bp_d_rdata", d_rsp_rdata, 32'h55);
    chk1("bp_rsp_d_ready", d_req_ready, 1'b0);
    tick(); bus_rsp_valid = 1'b0; #1;
    chk("bp_idle", 32'(dut.state), 32'(IDLE));

    // flush while fetch 0x300 waits for its response
    tick(); i_req_valid = 1'b1; i_req_addr = 32'h300; #1;
    chk1("fl_grant", i_req_ready, 1'b1);
    tick(); i_req_valid = 1'b0; #1;
    chk("fl_addr", bus_req_addr, 32'h300);
    tick(); i_flush = 1'b1; #1;
    chk("fl_in_rsp", 32'(dut.state), 32'(RSP));
    chk1("fl_no_rsp_yet", i_rsp_valid, 1'b0);
    tick(); i_flush = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hAAAA_AAAA; #1;
    chk1("fl_drop_set", dut.drop, 1'b1);
    chk1("fl_i_rsp_dropped", i_rsp_valid, 1'b0);
    chk1("fl_d_rsp", d_rsp_valid, 1'b0);
    tick(); bus_rsp_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h400; #1;
    chk("fl_idle", 32'(dut.state), 32'(IDLE));
    chk1("fl_drop_clr", dut.drop, 1'b0);
    chk1("fl_next_grant", i_req_ready, 1'b1);
    tick(); i_req_valid = 1'b0; #1;
    chk("fl_next_addr", bus_req_addr, 32'h400);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1234; #1;
    chk1("fl_next_rsp", i_rsp_valid, 1'b1);
    chk("fl_next_rdata", i_rsp_rdata, 32'h1234);
    tick(); bus_rsp_valid = 1'b0; #1;

    // flush in IDLE blocks the grant; flush with the response kills it
    tick(); i_req_valid = 1'b1; i_req_addr = 32'h500; i_flush = 1'b1; #1;
    chk1("fi_blocked", i_req_ready, 1'b0);
    tick(); i_flush = 1'b0; #1;
    chk1("fi_grant", i_req_ready, 1'b1);
    tick(); i_req_valid = 1'b0; #1;
    chk("fi_addr", bus_req_addr, 32'h500);
    tick(); i_flush = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h77; #1;
    chk1("fi_same_cycle", i_rsp_valid, 1'b0);
    tick(); i_flush = 1'b0; bus_rsp_valid = 1'b0; #1;
    chk("fi_idle", 32'(dut.state), 32'(IDLE));

    // reset during RSP, then a data load of 0x10
    tick(); i_req_valid = 1'b1; i_req_addr = 32'h600; #1;
    tick(); i_req_valid = 1'b0; #1;
    tick(); #1;
    chk("rm_in_rsp", 32'(dut.state), 32'(RSP));
    rst_n = 1'b0; d_req_valid = 1'b1; d_req_addr = 32'h10; d_req_wen = 1'b0; d_req_be = 4'hF; #1;
    chk("rm_state", 32'(dut.state), 32'(IDLE));
    chk("rm_owner", 32'(dut.owner), 32'(NONE));
    chk1("rm_bus_valid", bus_req_valid, 1'b0);
    chk("rm_bus_addr", bus_req_addr, 32'h0);
    chk1("rm_d_ready", d_req_ready, 1'b0);
    chk1("rm_i_ready", i_req_ready, 1'b0);
    chk1("rm_i_rsp", i_rsp_valid, 1'b0);
    tick(); rst_n = 1'b1; #1;
    chk1("rm_d_grant", d_req_ready, 1'b1);
    tick(); d_req_valid = 1'b0; #1;
    chk("rm_load_addr", bus_req_addr, 32'h10);
    chk1("rm_load_wen", bus_req_wen, 1'b0);
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFE; #1;
    chk1("rm_d_rsp", d_rsp_valid, 1'b1);
    chk("rm_d_rdata", d_rsp_rdata, 32'hCAFE);
    tick(); bus_rsp_valid = 1'b0; #1;
    chk("rm_idle", 32'(dut.state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one memory bus port between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the 5-stage core.
- Accepts one request at a time from either requester and holds it in a registered request slot.
- Issues the request on the bus, then routes the response back to the requester that owns it.
- Data requests win arbitration by default. A starvation counter guarantees fetch progress, and a fetch flush discards any fetch response still in flight.

Parameters:
- MAX_I_WAIT, 4: number of consecutive lost arbitrations after which fetch gets priority. Legal range 1..255.
- XLEN, 32: address and data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  XLEN  fetch address, word-aligned
- i_flush  in  1  fetch redirect; cancels the fetch request or response
- i_rsp_valid  out  1  fetch read data valid
- i_rsp_rdata  out  XLEN  fetch read data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  XLEN  data address
- d_req_wen  in  1  1 = store, 0 = load
- d_req_wdata  in  XLEN  store data, already lane-aligned
- d_req_be  in  XLEN/8  byte enables
- d_rsp_valid  out  1  data response; load data or store acknowledge
- d_rsp_rdata  out  XLEN  load data
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts the request
- bus_req_addr  out  XLEN
- bus_req_wen  out  1
- bus_req_wdata  out  XLEN
- bus_req_be  out  XLEN/8
- bus_rsp_valid  in  1  single-cycle response pulse
- bus_rsp_rdata  in  XLEN

Behaviour:
- Reset: the following are 0.
  - state = IDLE, owner = NONE
  - drop flag, wait counter
  - all request-slot registers
  - all ready and valid outputs
- FSM states are IDLE, REQ and RSP. One transaction is outstanding at most.
- IDLE arbitration is combinational over the current valid inputs.
  - Data is granted if d_req_valid = 1 and either the wait counter < MAX_I_WAIT or i_req_valid = 0.
  - Otherwise fetch is granted if i_req_valid = 1 and i_flush = 0.
  - The granted requester's *_req_ready is 1 for exactly that cycle.
  - The other requester's ready is 0, and both readies are 0 outside IDLE.
- On grant:
  - addr, wen, wdata and be are latched into the slot; a fetch is latched with wen = 0 and be = all ones.
  - owner is set and the FSM moves to REQ.
- REQ:
  - bus_req_valid = 1 and the bus_req_* outputs come from the slot registers only, so they stay stable until the handshake.
  - On bus_req_ready = 1 the FSM moves to RSP.
- RSP:
  - Waits for bus_rsp_valid.
  - The response is routed combinationally in the same cycle: *_rsp_valid = bus_rsp_valid & (owner match) & ~drop.
  - *_rsp_rdata = bus_rsp_rdata; d_rsp_rdata is don't-care for a store ack.
  - The FSM then returns to IDLE, clearing owner and drop.
- A bus response arriving in REQ or IDLE is a protocol error: it is ignored, and the assertion fires in simulation.
- Latency: grant at cycle t, bus_req_valid from t+1. Fastest response is at t+2 (ready at t+1, response at t+2). Next grant at t+3 at the earliest.
- Wait counter:
  - Increments, saturating at MAX_I_WAIT, on every IDLE cycle where data is granted while i_req_valid = 1.
  - Clears on any fetch grant.
- Flush:
  - When i_flush = 1 with owner = FETCH in REQ or RSP, drop is set. The transaction still completes on the bus and i_rsp_valid is suppressed.
  - A flush in the same cycle as bus_rsp_valid also suppresses the response.
  - A flush in IDLE blocks fetch grant that cycle.
  - A flush never affects a data transaction.
- When both requesters are idle the FSM stays in IDLE with no bus activity.

Decomposition:
- The shared package core_mem_pkg holds:
  - arb_state_t enum (IDLE, REQ, RSP)
  - arb_owner_t enum (NONE, FETCH, DATA)
  - mem_req_t struct (addr, wen, wdata, be)
- No sub-module: the FSM, slot register and counter are a single module.

Test Plan:
- Lone fetch: i_req_valid = 1, addr 0x0000_0100, bus ready immediately, response 0x0000_0013 one cycle later.
  → i_req_ready at t, bus_req_addr 0x100 at t+1, i_rsp_valid and rdata 0x13 at t+2, no d_rsp_valid.
- Simultaneous requests: fetch 0x200, data store 0x8000_0004 with wdata 0xDEADBEEF and be 0b1111.
  → Data is granted first with bus_req_wen = 1; fetch is granted in the next IDLE; the counter reads 1 and then 0.
- Starvation: MAX_I_WAIT = 4, fetch held valid, data valid continuously.
  → Data wins 4 arbitrations and fetch wins the 5th while d_req_valid is still 1.
- Bus backpressure: bus_req_ready low for 5 cycles.
  → bus_req_* stay stable and both readies stay 0 until the handshake.
- Flush in RSP: fetch 0x300 outstanding, i_flush pulsed, then bus response 0xAAAA_AAAA.
  → No i_rsp_valid, FSM returns to IDLE, and a fetch of 0x400 is then serviced normally.
- Reset mid-transaction: rst_n low during RSP.
  → All outputs go to 0 immediately; after release the FSM is in IDLE and a new data load of 0x10 completes.
